// File: rtl/flow_led_pkg.sv
// Shared encodings for the flowing-LED scheduler.
// Mode order, direction levels and LED count live here.
package flow_led_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_PING = 2'd2
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int   LED_N    = 8;

  function automatic mode_e next_mode(input mode_e m);
    mode_e r;
    case (m)
      MODE_UP:   r = MODE_DOWN;
      MODE_DOWN: r = MODE_PING;
      default:   r = MODE_UP;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer, level debouncer and press-edge pulse
// for one active-low key.
module key_debounce #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYC);

  logic          sync1_q, sync2_q;
  logic          lvl_q, lvl_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count only while the synced level disagrees with the accepted one.
  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == CW'(DEB_CYC - 1)) begin
        lvl_d   = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      lvl_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/flow_led_sched.sv
// Flowing-LED scheduler: prescaler, mode/run control and
// LED position stepping with debounced mode and pause keys.
module flow_led_sched
  import flow_led_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int DEB_CYC  = 1_000_000
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       key_mode_n,
  input  logic       key_pause_n,
  output logic [2:0] led_pos,
  output logic       led_dir,
  output logic       led_run,
  output logic [1:0] mode,
  output logic       step,
  output logic [7:0] flow_led
);

  localparam int PW = $clog2(TICK_DIV);

  logic          mode_press, pause_press, tick;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    pos_q, pos_d;
  logic          dir_q, dir_d;
  logic          run_q, run_d;
  logic          step_q, step_d;
  mode_e         mode_q, mode_d;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_key_mode (
    .clk   (clk_50m),
    .rst   (rst),
    .key_n (key_mode_n),
    .press (mode_press)
  );

  key_debounce #(.DEB_CYC(DEB_CYC)) u_key_pause (
    .clk   (clk_50m),
    .rst   (rst),
    .key_n (key_pause_n),
    .press (pause_press)
  );

  assign tick = run_q && (pre_q == PW'(TICK_DIV - 1));

  always_comb begin
    pre_d  = pre_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    run_d  = run_q;
    mode_d = mode_q;
    step_d = 1'b0;
    if (run_q) pre_d = tick ? '0 : pre_q + PW'(1);
    // A mode change swallows a coincident tick.
    if (mode_press) begin
      mode_d = next_mode(mode_q);
      pre_d  = '0;
      case (mode_d)
        MODE_UP:   dir_d = DIR_UP;
        MODE_DOWN: dir_d = DIR_DOWN;
        default:   dir_d = dir_q;
      endcase
    end else if (tick) begin
      step_d = 1'b1;
      case (mode_q)
        MODE_DOWN: begin
          pos_d = pos_q - 3'd1;
          dir_d = DIR_DOWN;
        end
        MODE_PING: begin
          if (dir_q && pos_q == 3'd7) begin
            dir_d = DIR_DOWN;
            pos_d = 3'd6;
          end else if (!dir_q && pos_q == 3'd0) begin
            dir_d = DIR_UP;
            pos_d = 3'd1;
          end else begin
            pos_d = dir_q ? pos_q + 3'd1 : pos_q - 3'd1;
          end
        end
        default: begin
          pos_d = pos_q + 3'd1;
          dir_d = DIR_UP;
        end
      endcase
    end
    if (pause_press) run_d = ~run_q;
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      pos_q  <= 3'd0;
      dir_q  <= DIR_UP;
      run_q  <= 1'b1;
      mode_q <= MODE_UP;
      step_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      run_q  <= run_d;
      mode_q <= mode_d;
      step_q <= step_d;
    end
  end

  assign led_pos  = pos_q;
  assign led_dir  = dir_q;
  assign led_run  = run_q;
  assign mode     = mode_q;
  assign step     = step_q;
  assign flow_led = 8'h01 << pos_q;

endmodule

// File: tb/tb_flow_led_sched.sv
// Scoreboard bench for flow_led_sched: a behavioural model predicts
// every step; a monitor pops and compares whenever step pulses.
module tb_flow_led_sched;

  localparam int TD = 4;
  localparam int DB = 3;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode_n = 1'b1;
  logic       key_pause_n = 1'b1;
  logic [2:0] led_pos;
  logic       led_dir, led_run, step;
  logic [1:0] mode;
  logic [7:0] flow_led;

  flow_led_sched #(.TICK_DIV(TD), .DEB_CYC(DB)) dut (
    .clk_50m     (clk_50m),
    .rst         (rst),
    .key_mode_n  (key_mode_n),
    .key_pause_n (key_pause_n),
    .led_pos     (led_pos),
    .led_dir     (led_dir),
    .led_run     (led_run),
    .mode        (mode),
    .step        (step),
    .flow_led    (flow_led)
  );

  always #5 clk_50m = ~clk_50m;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int cyc;
    int pos;
    int dir;
    int mode;
  } exp_t;
  exp_t sb[$];

  int m_s1[2], m_s2[2], m_lvl[2], m_cnt[2], m_prs[2];
  int m_mode = 0, m_pos = 0, m_dir = 1, m_run = 1, m_phase = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 1; m_s2[k] = 1; m_lvl[k] = 1;
      m_cnt[k] = 0; m_prs[k] = 0;
    end
    m_mode = 0; m_pos = 0; m_dir = 1; m_run = 1; m_phase = 0;
    sb.delete();
  endtask

  task automatic model_edge();
    bit tk;
    int raw, np;
    cyc++;
    tk = (m_run == 1) && (m_phase == TD - 1);
    if (m_prs[0] == 1) begin
      m_mode = (m_mode + 1) % 3;
      m_phase = 0;
      if (m_mode == 0) m_dir = 1;
      else if (m_mode == 1) m_dir = 0;
    end else if (tk) begin
      m_phase = 0;
      if (m_mode == 1) begin
        m_pos = (m_pos + 7) % 8; m_dir = 0;
      end else if (m_mode == 2) begin
        if (m_dir == 1 && m_pos == 7) begin m_dir = 0; m_pos = 6; end
        else if (m_dir == 0 && m_pos == 0) begin m_dir = 1; m_pos = 1; end
        else m_pos = (m_dir == 1) ? m_pos + 1 : m_pos - 1;
      end else begin
        m_pos = (m_pos + 1) % 8; m_dir = 1;
      end
      sb.push_back('{cyc, m_pos, m_dir, m_mode});
    end else if (m_run == 1) begin
      m_phase++;
    end
    if (m_prs[1] == 1) m_run = 1 - m_run;
    for (int k = 0; k < 2; k++) begin
      raw = (k == 0) ? int'(key_mode_n) : int'(key_pause_n);
      np = 0;
      if (m_s2[k] != m_lvl[k]) begin
        m_cnt[k]++;
        if (m_cnt[k] == DB) begin
          m_lvl[k] = m_s2[k];
          m_cnt[k] = 0;
          np = (m_lvl[k] == 0) ? 1 : 0;
        end
      end else begin
        m_cnt[k] = 0;
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = raw;
      m_prs[k] = np;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_50m or posedge rst);
      if (rst) model_reset();
      else model_edge();
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_50m);
      if (!rst) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL step_missing expected at cyc %0d pos %0d, now cyc %0d",
                   e.cyc, e.pos, cyc);
        end
        if (step) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL step_unexpected cyc %0d got pos %0d", cyc, led_pos);
          end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || int'(led_pos) != e.pos || int'(led_dir) != e.dir
                || int'(mode) != e.mode || flow_led != (8'h01 << e.pos)) begin
              errors++;
              $display("FAIL step cyc %0d got pos %0d dir %0d mode %0d led %h, need cyc %0d pos %0d dir %0d mode %0d",
                       cyc, led_pos, led_dir, mode, flow_led, e.cyc, e.pos, e.dir, e.mode);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d need %0d", name, act, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic hold_key(input int k, input int n);
    if (k != 1) key_mode_n = 1'b0;
    if (k != 0) key_pause_n = 1'b0;
    cyc_wait(n);
    key_mode_n = 1'b1;
    key_pause_n = 1'b1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_pos"}, int'(led_pos), m_pos);
    chk({tag, "_dir"}, int'(led_dir), m_dir);
    chk({tag, "_mode"}, int'(mode), m_mode);
    chk({tag, "_run"}, int'(led_run), m_run);
    chk({tag, "_led"}, int'(flow_led), 1 << m_pos);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pos"}, int'(led_pos), 0);
    chk({tag, "_dir"}, int'(led_dir), 1);
    chk({tag, "_mode"}, int'(mode), 0);
    chk({tag, "_run"}, int'(led_run), 1);
    chk({tag, "_step"}, int'(step), 0);
    chk({tag, "_led"}, int'(flow_led), 1);
  endtask

  initial begin
    int p;
    cyc_wait(3);
    chk_reset("rst");
    rst = 1'b0;
    cyc_wait(3);
    chk("first_step_early", int'(step), 0);
    cyc_wait(1);
    chk("first_step", int'(step), 1);
    chk("first_pos", int'(led_pos), 1);
    cyc_wait(36);
    chk_model("wrap");

    hold_key(0, 2);
    cyc_wait(10);
    chk("bounce_mode", int'(mode), 0);
    hold_key(0, 6);
    cyc_wait(6);
    chk("down_mode", int'(mode), 1);
    chk("down_dir", int'(led_dir), 0);
    cyc_wait(20);
    chk_model("down");

    hold_key(0, 4);
    cyc_wait(6);
    hold_key(0, 4);
    cyc_wait(6);
    for (int i = 0; i < 40 && m_pos != 5; i++) cyc_wait(1);
    hold_key(0, 4);
    cyc_wait(4);
    hold_key(0, 4);
    cyc_wait(6);
    chk("ping_mode", int'(mode), 2);
    cyc_wait(80);
    chk_model("ping");

    hold_key(1, 4);
    cyc_wait(6);
    chk("pause_run", int'(led_run), 0);
    p = m_pos;
    cyc_wait(40);
    chk("pause_pos", int'(led_pos), p);
    hold_key(0, 4);
    cyc_wait(10);
    chk("pause_mode_run", int'(led_run), 0);
    chk_model("pause_mode");
    hold_key(1, 4);
    cyc_wait(20);
    chk_model("resume");

    for (int off = 0; off < 8; off++) begin
      cyc_wait(off % TD);
      hold_key(0, 4);
      cyc_wait(9);
    end
    chk_model("collide");

    repeat (40) begin
      hold_key($urandom_range(0, 2), $urandom_range(1, 7));
      cyc_wait($urandom_range(1, 15));
    end
    cyc_wait(20);
    chk_model("random");

    for (int i = 0; i < 3 && m_mode != 2; i++) begin
      hold_key(0, 4);
      cyc_wait(6);
    end
    chk("pre_rst_mode", int'(mode), 2);
    key_mode_n = 1'b0;
    cyc_wait(2);
    #2 rst = 1'b1;
    #1 chk_reset("mid_rst");
    cyc_wait(1);
    key_mode_n = 1'b1;
    cyc_wait(2);
    rst = 1'b0;
    cyc_wait(20);
    chk("post_rst_mode", int'(mode), 0);
    chk_model("post_rst");

    cyc_wait(5);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
